// File: rtl/register_file.sv
// 2**ADDR_W x DATA_W register file, two read ports, one write port and a debug port. Reads are combinational; writes take effect at the clock edge; no backpressure.
// Entry 0 is hardwired to zero. Defining REGFILE_BYPASS_EN forwards same-cycle write data to readdata1/readdata2, but never to dbg_data.
module register_file #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] readreg1,
    input  logic [ADDR_W-1:0] readreg2,
    input  logic [ADDR_W-1:0] writereg,
    input  logic [DATA_W-1:0] writedata,
    input  logic              regwrite,
    output logic [DATA_W-1:0] readdata1,
    output logic [DATA_W-1:0] readdata2,
    input  logic [ADDR_W-1:0] dbg_addr,
    output logic [DATA_W-1:0] dbg_data
);

    localparam int DEPTH = 2 ** ADDR_W;

    logic [DATA_W-1:0] regs [DEPTH];
    logic              wr_en;

    // Gating on regwrite first means X on the index or data cannot leak into state.
    assign wr_en = regwrite && (writereg != '0);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                regs[i] <= '0;
            end
        end else if (wr_en) begin
            regs[writereg] <= writedata;
        end
    end

    always_comb begin
        readdata1 = '0;
        readdata2 = '0;
        dbg_data  = '0;
        if (!reset) begin
            if (readreg1 != '0) readdata1 = regs[readreg1];
            if (readreg2 != '0) readdata2 = regs[readreg2];
            if (dbg_addr != '0) dbg_data  = regs[dbg_addr];
`ifdef REGFILE_BYPASS_EN
            if (wr_en && (readreg1 == writereg)) readdata1 = writedata;
            if (wr_en && (readreg2 == writereg)) readdata2 = writedata;
`endif
        end
    end

endmodule

// File: tb/tb_register_file.sv
// Scoreboard bench for register_file: expected reads are queued when inputs are driven and checked when the outputs settle.
module tb_register_file;

    localparam int DW = 32;
    localparam int AW = 5;

    logic          clk = 1'b0;
    logic          reset;
    logic [AW-1:0] readreg1, readreg2, writereg, dbg_addr;
    logic [DW-1:0] writedata;
    logic          regwrite;
    logic [DW-1:0] readdata1, readdata2, dbg_data;

    register_file #(.DATA_W(DW), .ADDR_W(AW)) dut (
        .clk       (clk),
        .reset     (reset),
        .readreg1  (readreg1),
        .readreg2  (readreg2),
        .writereg  (writereg),
        .writedata (writedata),
        .regwrite  (regwrite),
        .readdata1 (readdata1),
        .readdata2 (readdata2),
        .dbg_addr  (dbg_addr),
        .dbg_data  (dbg_data)
    );

    always #5 clk = ~clk;

    typedef struct {
        string         tag;
        logic [DW-1:0] e1;
        logic [DW-1:0] e2;
        logic [DW-1:0] ed;
    } exp_t;

    exp_t          sb[$];
    logic [DW-1:0] model [2**AW];
    int            total = 0;
    int            bad   = 0;

    task automatic chk(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [DW-1:0] exp_rd(input logic [AW-1:0] rr, input logic bypass_ok);
        if (reset) return '0;
        if (rr == '0) return '0;
`ifdef REGFILE_BYPASS_EN
        if (bypass_ok && (regwrite === 1'b1) && (writereg != '0) && (writereg == rr)) return writedata;
`endif
        return model[rr];
    endfunction

    task automatic push_exp(input string tag);
        exp_t e;
        e.tag = tag;
        e.e1  = exp_rd(readreg1, 1'b1);
        e.e2  = exp_rd(readreg2, 1'b1);
        e.ed  = exp_rd(dbg_addr, 1'b0);
        sb.push_back(e);
    endtask

    task automatic pop_chk();
        exp_t e;
        if (sb.size() == 0) begin
            chk("sb_empty", 32'd1, 32'd0);
            return;
        end
        e = sb.pop_front();
        chk({e.tag, ".rd1"}, readdata1, e.e1);
        chk({e.tag, ".rd2"}, readdata2, e.e2);
        chk({e.tag, ".dbg"}, dbg_data,  e.ed);
    endtask

    // Called at a negedge: drive, check settled outputs, take the posedge, update the model.
    task automatic step(input string tag, input logic [AW-1:0] r1, input logic [AW-1:0] r2,
                        input logic [AW-1:0] wr, input logic [DW-1:0] wd, input logic we,
                        input logic [AW-1:0] da);
        readreg1  = r1;
        readreg2  = r2;
        writereg  = wr;
        writedata = wd;
        regwrite  = we;
        dbg_addr  = da;
        push_exp(tag);
        #2;
        pop_chk();
        @(posedge clk);
        if ((we === 1'b1) && (wr != '0) && !reset) model[wr] = wd;
        @(negedge clk);
    endtask

    initial begin
        for (int i = 0; i < 2**AW; i++) model[i] = '0;
        reset = 1'b1;
        readreg1 = '0; readreg2 = '0; writereg = '0; dbg_addr = '0;
        writedata = '0; regwrite = 1'b0;
        @(negedge clk);

        // Held in reset: reads are zero and a write attempt is dropped.
        step("rst_hold", 5'd4, 5'd31, 5'd4, 32'hCAFE_F00D, 1'b1, 5'd4);
        reset = 1'b0;
        step("post_rst", 5'd4, 5'd31, 5'd0, 32'h0, 1'b0, 5'd4);

        // Basic write and read-back on both ports.
        step("wr3", 5'd0, 5'd0, 5'd3, 32'hDEAD_BEEF, 1'b1, 5'd0);
        step("rd3", 5'd3, 5'd3, 5'd0, 32'h0, 1'b0, 5'd3);

        // Entry 0 discards writes.
        step("wr0", 5'd0, 5'd0, 5'd0, 32'h1234_5678, 1'b1, 5'd0);
        step("rd0", 5'd0, 5'd0, 5'd0, 32'h0, 1'b0, 5'd0);

        // Same-cycle read of the written index.
        step("wr7a", 5'd0, 5'd0, 5'd7, 32'h0000_0001, 1'b1, 5'd0);
        step("wr7b", 5'd7, 5'd7, 5'd7, 32'hA5A5_A5A5, 1'b1, 5'd7);
        step("rd7",  5'd7, 5'd3, 5'd0, 32'h0, 1'b0, 5'd7);

        // X on write controls with regwrite low must not corrupt anything.
        step("xwr", 5'd3, 5'd7, 'x, 'x, 1'b0, 5'd3);
        step("xchk", 5'd3, 5'd7, 5'd0, 32'h0, 1'b0, 5'd7);

        // Load entries, then pulse reset between edges and read without any clock.
        step("wr5",  5'd0, 5'd0, 5'd5,  32'h5555_0005, 1'b1, 5'd0);
        step("wr31", 5'd0, 5'd0, 5'd31, 32'h3131_3131, 1'b1, 5'd0);
        step("wr17", 5'd5, 5'd31, 5'd17, 32'h1717_1717, 1'b1, 5'd0);
        #1 reset = 1'b1;
        #1 reset = 1'b0;
        for (int i = 0; i < 2**AW; i++) model[i] = '0;
        readreg1 = 5'd5; readreg2 = 5'd31; dbg_addr = 5'd17; regwrite = 1'b0;
        push_exp("async_rst");
        #1;
        pop_chk();
        @(negedge clk);

        // Reset coincident with a write: the write is lost.
        step("wr9", 5'd0, 5'd0, 5'd9, 32'h0000_0099, 1'b1, 5'd9);
        reset = 1'b1;
        for (int i = 0; i < 2**AW; i++) model[i] = '0;
        step("rst_wr9", 5'd9, 5'd9, 5'd9, 32'hFFFF_FFFF, 1'b1, 5'd9);
        reset = 1'b0;
        // First edge with reset low takes the write.
        step("rd9", 5'd9, 5'd9, 5'd10, 32'h1010_1010, 1'b1, 5'd9);
        step("rd10", 5'd10, 5'd9, 5'd0, 32'h0, 1'b0, 5'd10);

        // Random soak; readreg1 often aliases writereg to exercise same-cycle reads.
        for (int n = 0; n < 10000; n++) begin
            logic [AW-1:0] wr;
            wr = AW'($urandom_range(0, 2**AW - 1));
            step("soak",
                 ($urandom_range(0, 3) == 0) ? wr : AW'($urandom_range(0, 2**AW - 1)),
                 AW'($urandom_range(0, 2**AW - 1)),
                 wr, $urandom, 1'($urandom_range(0, 1)),
                 ($urandom_range(0, 3) == 0) ? wr : AW'($urandom_range(0, 2**AW - 1)));
        end

        if (sb.size() != 0) chk("sb_leftover", DW'(sb.size()), '0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
